// File: rtl/bsg_bp_mmio_responder_pkg.sv
// Shared types for the MMIO responder: BedRock message types, size codes, FSM states.
package bsg_bp_mmio_responder_pkg;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_mem_msg_e;

  localparam logic [2:0] e_size_1 = 3'd0;
  localparam logic [2:0] e_size_2 = 3'd1;
  localparam logic [2:0] e_size_4 = 3'd2;
  localparam logic [2:0] e_size_8 = 3'd3;

  typedef enum logic {
    e_idle,
    e_resp
  } mmio_state_e;

endpackage

// File: rtl/bsg_bp_mmio_wmask.sv
// Byte-enable mask for a size/offset pair; flags misaligned or illegal sizes.
module bsg_bp_mmio_wmask
  import bsg_bp_mmio_responder_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [2:0] offset_i,
  output logic [7:0] mask_o,
  output logic       misalign_o
);

  logic [7:0] base_mask;

  always_comb begin
    base_mask  = '0;
    misalign_o = 1'b0;
    case (size_i)
      e_size_1: base_mask = 8'h01;
      e_size_2: begin
        base_mask  = 8'h03;
        misalign_o = offset_i[0];
      end
      e_size_4: begin
        base_mask  = 8'h0F;
        misalign_o = |offset_i[1:0];
      end
      e_size_8: begin
        base_mask  = 8'hFF;
        misalign_o = |offset_i;
      end
      // Sizes 4..7 are illegal: no bytes enabled, reported as an error.
      default: misalign_o = 1'b1;
    endcase
    mask_o = base_mask << offset_i;
  end

endmodule

// File: rtl/bsg_bp_mmio_responder.sv
// Single-outstanding MMIO register file responder: accepts one command, answers
// it one cycle later, and waits for resp_yumi_i before accepting another.
module bsg_bp_mmio_responder
  import bsg_bp_mmio_responder_pkg::*;
#(
  parameter int els_p           = 8,
  parameter     base_addr_p     = 40'h0010_0000,
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic [3:0]                 cmd_msg_type_i,
  input  logic [paddr_width_p-1:0]   cmd_addr_i,
  input  logic [2:0]                 cmd_size_i,
  input  logic [payload_width_p-1:0] cmd_payload_i,
  input  logic [63:0]                cmd_data_i,
  output logic                       resp_v_o,
  input  logic                       resp_yumi_i,
  output logic [3:0]                 resp_msg_type_o,
  output logic [paddr_width_p-1:0]   resp_addr_o,
  output logic [2:0]                 resp_size_o,
  output logic [payload_width_p-1:0] resp_payload_o,
  output logic [63:0]                resp_data_o,
  output logic [els_p*64-1:0]        regs_o,
  output logic [7:0]                 err_count_o
);

  localparam int idx_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [paddr_width_p-1:0] base_lp   = paddr_width_p'(base_addr_p);
  localparam logic [paddr_width_p-1:0] window_lp = paddr_width_p'(els_p * 8);

  mmio_state_e                state_q, state_d;
  logic                       live_q;
  logic [els_p*64-1:0]        regs_q, regs_d;
  logic [7:0]                 err_q, err_d;
  logic [3:0]                 resp_msg_type_q, resp_msg_type_d;
  logic [paddr_width_p-1:0]   resp_addr_q, resp_addr_d;
  logic [2:0]                 resp_size_q, resp_size_d;
  logic [payload_width_p-1:0] resp_payload_q, resp_payload_d;
  logic [63:0]                resp_data_q, resp_data_d;

  logic [paddr_width_p-1:0] diff;
  logic [idx_w-1:0]         idx;
  logic [2:0]               offset;
  logic [7:0]               wmask;
  logic                     misalign, in_window, type_ok, is_write, err, accept;
  logic [63:0]              cur_reg, wdata, rmask;
  int unsigned              reg_lsb;

  bsg_bp_mmio_wmask wmask_u (
    .size_i    (cmd_size_i),
    .offset_i  (offset),
    .mask_o    (wmask),
    .misalign_o(misalign)
  );

  assign cmd_ready_o = (state_q == e_idle) && live_q;
  assign accept      = cmd_v_i && cmd_ready_o;

  always_comb begin
    offset    = cmd_addr_i[2:0];
    diff      = cmd_addr_i - base_lp;
    in_window = (cmd_addr_i >= base_lp) && (diff < window_lp);
    idx       = diff[idx_w+2:3];
    reg_lsb   = 32'(idx) << 6;
    cur_reg   = regs_q[reg_lsb +: 64];
    type_ok   = (cmd_msg_type_i <= 4'd3);
    is_write  = (cmd_msg_type_i == e_bedrock_mem_wr) || (cmd_msg_type_i == e_bedrock_mem_uc_wr);
    err       = !in_window || misalign || cmd_size_i[2] || !type_ok;
    wdata     = cmd_data_i << {offset, 3'b000};
    case (cmd_size_i)
      e_size_1: rmask = 64'h0000_0000_0000_00FF;
      e_size_2: rmask = 64'h0000_0000_0000_FFFF;
      e_size_4: rmask = 64'h0000_0000_FFFF_FFFF;
      default:  rmask = '1;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    regs_d          = regs_q;
    err_d           = err_q;
    resp_msg_type_d = resp_msg_type_q;
    resp_addr_d     = resp_addr_q;
    resp_size_d     = resp_size_q;
    resp_payload_d  = resp_payload_q;
    resp_data_d     = resp_data_q;
    case (state_q)
      e_idle: if (accept) begin
        state_d         = e_resp;
        resp_msg_type_d = cmd_msg_type_i;
        resp_addr_d     = cmd_addr_i;
        resp_size_d     = cmd_size_i;
        resp_payload_d  = cmd_payload_i;
        resp_data_d     = '0;
        if (err) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else if (is_write) begin
          for (int unsigned b = 0; b < 8; b++)
            if (wmask[b]) regs_d[reg_lsb + 8*b +: 8] = wdata[8*b +: 8];
        end else begin
          resp_data_d = (cur_reg >> {offset, 3'b000}) & rmask;
        end
      end
      e_resp: if (resp_yumi_i) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  // live_q keeps cmd_ready_o low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= e_idle;
      live_q          <= 1'b0;
      regs_q          <= '0;
      err_q           <= '0;
      resp_msg_type_q <= '0;
      resp_addr_q     <= '0;
      resp_size_q     <= '0;
      resp_payload_q  <= '0;
      resp_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      live_q          <= 1'b1;
      regs_q          <= regs_d;
      err_q           <= err_d;
      resp_msg_type_q <= resp_msg_type_d;
      resp_addr_q     <= resp_addr_d;
      resp_size_q     <= resp_size_d;
      resp_payload_q  <= resp_payload_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign resp_v_o        = (state_q == e_resp);
  assign resp_msg_type_o = resp_msg_type_q;
  assign resp_addr_o     = resp_addr_q;
  assign resp_size_o     = resp_size_q;
  assign resp_payload_o  = resp_payload_q;
  assign resp_data_o     = resp_data_q;
  assign regs_o          = regs_q;
  assign err_count_o     = err_q;

endmodule

// File: tb/tb_bsg_bp_mmio_responder.sv
// Randomized self-checking bench for bsg_bp_mmio_responder against a byte-array model.
module tb_bsg_bp_mmio_responder;

  localparam int          ELS  = 8;
  localparam logic [39:0] BASE = 40'h0010_0000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_v = 1'b0;
  logic              cmd_ready_o;
  logic [3:0]        cmd_msg_type = '0;
  logic [39:0]       cmd_addr = '0;
  logic [2:0]        cmd_size = '0;
  logic [15:0]       cmd_payload = '0;
  logic [63:0]       cmd_data = '0;
  logic              resp_v_o;
  logic              resp_yumi = 1'b0;
  logic [3:0]        resp_msg_type_o;
  logic [39:0]       resp_addr_o;
  logic [2:0]        resp_size_o;
  logic [15:0]       resp_payload_o;
  logic [63:0]       resp_data_o;
  logic [ELS*64-1:0] regs_o;
  logic [7:0]        err_count_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] mreg [ELS][8];
  int         merr = 0;

  always #5 clk = ~clk;

  bsg_bp_mmio_responder #(
    .els_p          (ELS),
    .base_addr_p    (BASE),
    .paddr_width_p  (40),
    .payload_width_p(16)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .cmd_v_i        (cmd_v),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_msg_type_i (cmd_msg_type),
    .cmd_addr_i     (cmd_addr),
    .cmd_size_i     (cmd_size),
    .cmd_payload_i  (cmd_payload),
    .cmd_data_i     (cmd_data),
    .resp_v_o       (resp_v_o),
    .resp_yumi_i    (resp_yumi),
    .resp_msg_type_o(resp_msg_type_o),
    .resp_addr_o    (resp_addr_o),
    .resp_size_o    (resp_size_o),
    .resp_payload_o (resp_payload_o),
    .resp_data_o    (resp_data_o),
    .regs_o         (regs_o),
    .err_count_o    (err_count_o)
  );

  function automatic logic [ELS*64-1:0] model_regs();
    logic [ELS*64-1:0] v;
    v = '0;
    for (int r = 0; r < ELS; r++)
      for (int b = 0; b < 8; b++) v[r*64 + b*8 +: 8] = mreg[r][b];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ELS; r++)
      for (int b = 0; b < 8; b++) mreg[r][b] = 8'h00;
    merr = 0;
  endtask

  // Applies one accepted command to the model; returns the expected resp data.
  task automatic model_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] sz,
                           input logic [63:0] d, output logic [63:0] rd);
    int   n, off, idx;
    bit   er;
    rd  = '0;
    er  = (t > 3) || (sz > 3) || (a < BASE) || (a >= BASE + ELS*8);
    n   = 1 << sz;
    off = int'(a % 8);
    if (off % n != 0) er = 1;
    if (er) begin
      if (merr < 255) merr++;
      return;
    end
    idx = int'((a - BASE) / 8);
    for (int k = 0; k < n; k++)
      if (t == 1 || t == 3) mreg[idx][off+k] = d[8*k +: 8];
      else rd[8*k +: 8] = mreg[idx][off+k];
  endtask

  task automatic present(input logic [3:0] t, input logic [39:0] a, input logic [2:0] sz,
                         input logic [15:0] p, input logic [63:0] d);
    cmd_v = 1'b1; cmd_msg_type = t; cmd_addr = a; cmd_size = sz; cmd_payload = p; cmd_data = d;
  endtask

  // Full transaction: present, wait (bounded) for ready, check response, hold, then yumi.
  task automatic do_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] sz,
                        input logic [15:0] p, input logic [63:0] d, input int hold,
                        output logic [63:0] got);
    logic [63:0] exp;
    int w;
    got = 'x;
    @(negedge clk);
    present(t, a, sz, p, d);
    w = 0;
    while (!cmd_ready_o && w < 20) begin @(negedge clk); w++; end
    total++;
    if (!cmd_ready_o) begin
      bad++; $display("FAIL ready_timeout got=%b want=1", cmd_ready_o);
      cmd_v = 1'b0; return;
    end
    model_cmd(t, a, sz, d, exp);
    @(posedge clk); #1;
    cmd_v = 1'b0; cmd_payload = 16'($urandom); cmd_data = {$urandom, $urandom};
    @(negedge clk);
    total++;
    if (resp_v_o !== 1'b1 || resp_msg_type_o !== t || resp_addr_o !== a ||
        resp_size_o !== sz || resp_payload_o !== p) begin
      bad++; $display("FAIL resp_hdr got v=%b t=%h a=%h s=%h p=%h want v=1 t=%h a=%h s=%h p=%h",
                      resp_v_o, resp_msg_type_o, resp_addr_o, resp_size_o, resp_payload_o, t, a, sz, p);
    end
    total++;
    if (resp_data_o !== exp) begin
      bad++; $display("FAIL resp_data got=%h want=%h", resp_data_o, exp);
    end
    total++;
    if (regs_o !== model_regs()) begin
      bad++; $display("FAIL regs got=%h want=%h", regs_o, model_regs());
    end
    total++;
    if (err_count_o !== 8'(merr)) begin
      bad++; $display("FAIL err_count got=%0d want=%0d", err_count_o, merr);
    end
    got = resp_data_o;
    repeat (hold) begin
      @(negedge clk);
      total++;
      if (resp_v_o !== 1'b1 || resp_data_o !== exp || resp_payload_o !== p || cmd_ready_o !== 1'b0) begin
        bad++; $display("FAIL resp_hold got v=%b d=%h p=%h rdy=%b want v=1 d=%h p=%h rdy=0",
                        resp_v_o, resp_data_o, resp_payload_o, cmd_ready_o, exp, p);
      end
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    #12;
    total++;
    if (cmd_ready_o !== 1'b0 || resp_v_o !== 1'b0 || regs_o !== '0 || err_count_o !== 8'd0 ||
        resp_data_o !== '0 || resp_addr_o !== '0 || resp_payload_o !== '0) begin
      bad++; $display("FAIL reset_state got rdy=%b v=%b err=%0d want rdy=0 v=0 err=0",
                      cmd_ready_o, resp_v_o, err_count_o);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    total++;
    if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", cmd_ready_o); end
    @(posedge clk); #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b want=1", cmd_ready_o); end
  endtask

  task automatic test_directed();
    logic [63:0] g;
    do_cmd(4'd3, BASE + 8, 3'd3, 16'h0011, 64'h0123_4567_89AB_CDEF, 0, g);
    do_cmd(4'd2, BASE + 8, 3'd3, 16'h0012, 64'h0, 0, g);
    total++;
    if (g !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL rd64 got=%h want=0123456789abcdef", g); end
    total++;
    if (regs_o[127:64] !== 64'h0123_4567_89AB_CDEF) begin
      bad++; $display("FAIL reg1 got=%h want=0123456789abcdef", regs_o[127:64]);
    end
    do_cmd(4'd3, BASE + 10, 3'd1, 16'h0013, 64'h0000_0000_0000_BEEF, 0, g);
    total++;
    if (regs_o[127:64] !== 64'h0123_4567_BEEF_CDEF) begin
      bad++; $display("FAIL reg1_partial got=%h want=01234567beefcdef", regs_o[127:64]);
    end
    do_cmd(4'd2, BASE + 12, 3'd2, 16'h0014, 64'h0, 0, g);
    total++;
    if (g !== 64'h0000_0000_0123_4567) begin bad++; $display("FAIL rd32 got=%h want=0000000001234567", g); end
  endtask

  task automatic test_errors();
    logic [63:0] g;
    do_cmd(4'd2, BASE + 8*ELS, 3'd3, 16'h0021, 64'h0, 0, g);
    do_cmd(4'd3, BASE + 1, 3'd2, 16'h0022, 64'hFFFF_FFFF_FFFF_FFFF, 0, g);
    do_cmd(4'd5, BASE, 3'd3, 16'h0023, 64'hFFFF_FFFF_FFFF_FFFF, 0, g);
    total++;
    if (err_count_o !== 8'd3) begin bad++; $display("FAIL err_three got=%0d want=3", err_count_o); end
  endtask

  task automatic test_stall();
    logic [63:0] exp1, exp2;
    logic [15:0] p1, p2;
    int w;
    p1 = 16'($urandom); p2 = 16'($urandom);
    @(negedge clk);
    present(4'd0, BASE + 8, 3'd3, p1, 64'h0);
    w = 0;
    while (!cmd_ready_o && w < 20) begin @(negedge clk); w++; end
    model_cmd(4'd0, BASE + 8, 3'd3, 64'h0, exp1);
    @(posedge clk); #1;
    present(4'd0, BASE + 16, 3'd2, p2, 64'h0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      total++;
      if (cmd_ready_o !== 1'b0 || resp_v_o !== 1'b1 || resp_payload_o !== p1 ||
          resp_data_o !== exp1 || resp_addr_o !== BASE + 8) begin
        bad++; $display("FAIL stall_%0d got rdy=%b v=%b p=%h d=%h want rdy=0 v=1 p=%h d=%h",
                        i, cmd_ready_o, resp_v_o, resp_payload_o, resp_data_o, p1, exp1);
      end
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b want=1", cmd_ready_o); end
    model_cmd(4'd0, BASE + 16, 3'd2, 64'h0, exp2);
    @(posedge clk); #1;
    cmd_v = 1'b0;
    @(negedge clk);
    total++;
    if (resp_v_o !== 1'b1 || resp_payload_o !== p2 || resp_data_o !== exp2) begin
      bad++; $display("FAIL stall_second got v=%b p=%h d=%h want v=1 p=%h d=%h",
                      resp_v_o, resp_payload_o, resp_data_o, p2, exp2);
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [15:0] pay [N];
    logic [3:0]  ty  [N];
    logic [39:0] ad  [N];
    logic [63:0] dat [N];
    logic [63:0] exp;
    for (int k = 0; k < N; k++) begin
      pay[k] = 16'($urandom);
      ty[k]  = 4'($urandom_range(0, 3));
      ad[k]  = BASE + 40'(8 * $urandom_range(0, ELS-1));
      dat[k] = {$urandom, $urandom};
    end
    @(negedge clk);
    resp_yumi = 1'b1;
    present(ty[0], ad[0], 3'd3, pay[0], dat[0]);
    for (int k = 0; k < N; k++) begin
      total++;
      if (cmd_ready_o !== 1'b1 || resp_v_o !== 1'b0) begin
        bad++; $display("FAIL b2b_idle_%0d got rdy=%b v=%b want rdy=1 v=0", k, cmd_ready_o, resp_v_o);
      end
      model_cmd(ty[k], ad[k], 3'd3, dat[k], exp);
      @(negedge clk);
      total++;
      if (resp_v_o !== 1'b1 || resp_payload_o !== pay[k] || resp_data_o !== exp) begin
        bad++; $display("FAIL b2b_resp_%0d got v=%b p=%h d=%h want v=1 p=%h d=%h",
                        k, resp_v_o, resp_payload_o, resp_data_o, pay[k], exp);
      end
      if (k < N-1) present(ty[k+1], ad[k+1], 3'd3, pay[k+1], dat[k+1]);
      else cmd_v = 1'b0;
      @(negedge clk);
    end
    resp_yumi = 1'b0;
    total++;
    if (regs_o !== model_regs()) begin bad++; $display("FAIL b2b_regs got=%h want=%h", regs_o, model_regs()); end
  endtask

  task automatic test_random();
    logic [63:0] g;
    logic [3:0]  t;
    logic [2:0]  sz;
    logic [39:0] a;
    for (int i = 0; i < 60; i++) begin
      t  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a  = BASE + 40'($urandom_range(0, ELS*8 - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~(40'((1 << sz) - 1) & 40'h7);
      if ($urandom_range(0, 14) == 0) a = BASE - 40'($urandom_range(1, 64));
      do_cmd(t, a, sz, 16'($urandom), {$urandom, $urandom}, $urandom_range(0, 2), g);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] g;
    for (int i = 0; i < 260; i++)
      do_cmd(4'($urandom_range(4, 15)), BASE, 3'd3, 16'(i), 64'h0, 0, g);
    total++;
    if (err_count_o !== 8'd255) begin bad++; $display("FAIL err_saturate got=%0d want=255", err_count_o); end
  endtask

  task automatic test_reset_mid_resp();
    logic [63:0] g;
    int w;
    @(negedge clk);
    present(4'd1, BASE + 24, 3'd3, 16'hA5A5, 64'hDEAD_BEEF_CAFE_F00D);
    w = 0;
    while (!cmd_ready_o && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    cmd_v = 1'b0;
    @(negedge clk);
    total++;
    if (resp_v_o !== 1'b1) begin bad++; $display("FAIL rst_pre_resp got=%b want=1", resp_v_o); end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    total++;
    if (resp_v_o !== 1'b0 || resp_payload_o !== '0 || resp_addr_o !== '0 || resp_msg_type_o !== '0 ||
        resp_size_o !== '0 || resp_data_o !== '0 || regs_o !== '0 || err_count_o !== 8'd0 ||
        cmd_ready_o !== 1'b0) begin
      bad++; $display("FAIL rst_async got v=%b p=%h regs0=%h err=%0d rdy=%b want all zero",
                      resp_v_o, resp_payload_o, regs_o[63:0], err_count_o, cmd_ready_o);
    end
    #3;
    reset_n = 1'b1;
    for (int r = 0; r < ELS; r++) begin
      do_cmd(4'd0, BASE + 40'(8*r), 3'd3, 16'(r), 64'h0, 0, g);
      total++;
      if (g !== 64'h0) begin bad++; $display("FAIL rst_reg%0d got=%h want=0", r, g); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_stall();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/bsg_bp_mmio_responder.md
BSG_BP_MMIO_RESPONDER -- requirements
Module: bsg_bp_mmio_responder

Interface
REQ-001 SHALL have parameter els_p, default 8: number of 64-bit registers (power of 2, 2..64).
REQ-002 SHALL have parameter base_addr_p, default 40'h0010_0000: byte address of register 0; window spans els_p*8 bytes.
REQ-003 SHALL have parameter paddr_width_p, default 40: command address width.
REQ-004 SHALL have parameter payload_width_p, default 16: opaque command payload width, echoed in the response.
REQ-005 SHALL have ports, in this order:
- clk_i  in  1  sole clock; one clock domain.
- reset_n_i  in  1  asynchronous, active-low reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; transfer when cmd_v_i & cmd_ready_o.
- cmd_msg_type_i  in  4  BedRock mem msg type.
- cmd_addr_i  in  paddr_width_p  byte address.
- cmd_size_i  in  3  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B; 4..7 illegal.
- cmd_payload_i  in  payload_width_p  opaque payload.
- cmd_data_i  in  64  write data, LSB-aligned.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  response consumed; only asserted while resp_v_o.
- resp_msg_type_o  out  4  echoed type.
- resp_addr_o  out  paddr_width_p  echoed address.
- resp_size_o  out  3  echoed size.
- resp_payload_o  out  payload_width_p  echoed payload.
- resp_data_o  out  64  read data, LSB-aligned.
- regs_o  out  els_p*64  current register contents, register 0 at LSBs.
- err_count_o  out  8  saturating error count.

Function
REQ-006 SHALL implement a 2-state FSM, IDLE and RESP; cmd_ready_o=1 only in IDLE.
REQ-007 On handshake in IDLE SHALL capture all command fields, perform any write, and enter RESP next cycle; resp_v_o asserts exactly 1 cycle after acceptance.
REQ-008 In RESP SHALL hold resp_v_o and all resp_* outputs stable until resp_yumi_i; on yumi SHALL return to IDLE, so the next command is accepted no earlier than the cycle after yumi.
REQ-009 Types 0 (rd) and 2 (uc_rd) SHALL read; types 1 (wr) and 3 (uc_wr) SHALL write.
REQ-010 Index = (cmd_addr_i - base_addr_p) >> 3; byte offset = cmd_addr_i[2:0].
REQ-011 A write SHALL update only bytes offset..offset+2^size-1, taken from cmd_data_i low bytes; other bytes unchanged.
REQ-012 A read SHALL return register >> (8*offset), masked to 2^size bytes; upper bytes zero.
REQ-013 Error cases:
- address outside the window
- offset not a multiple of 2^size
- size > 3
- msg type not in {0,1,2,3}
For an error: no register change, resp_data_o=0, response still issued with echoed fields, err_count_o += 1, saturating at 255.
REQ-014 A write response SHALL carry resp_data_o=0.
REQ-015 regs_o SHALL reflect a write on the cycle after acceptance.
REQ-016 cmd_* inputs SHALL be ignored while cmd_ready_o=0.

Reset
REQ-017 Assertion of reset_n_i low SHALL, asynchronously:
- force IDLE
- clear all registers and err_count_o
- drive resp_v_o=0 and all resp_* outputs to 0
REQ-018 A reset during RESP SHALL drop the pending response without any handshake.
REQ-019 cmd_ready_o SHALL be 0 during reset and SHALL rise on the first clk_i edge after deassertion.

Structure
REQ-020 A shared package SHALL hold the msg-type enum (rd=0, wr=1, uc_rd=2, uc_wr=3) and the size encoding constants.
REQ-021 Byte-mask generation from size/offset SHALL be a sub-module, bsg_bp_mmio_wmask: size and offset in, 8-bit mask and misalign flag out.
REQ-022 Registers SHALL be flops, not SRAM.

Verification
REQ-023 uc_wr, addr=base+8, size 3, data 64'h0123_4567_89AB_CDEF; then uc_rd of the same -> read resp_data_o=64'h0123_4567_89AB_CDEF; regs_o[127:64] matches.
REQ-024 uc_wr, addr=base+8+2, size 1, data 16'hBEEF over REQ-023 contents -> register 1 = 64'h0123_4567_BEEF_CDEF; uc_rd at base+8+4, size 2 returns 64'h0000_0000_0123_4567.
REQ-025 Error commands in sequence:
- uc_rd at base+8*els_p
- uc_wr size 2 at base+1
- msg type 5
Each -> response with data 0, no register change, err_count_o=3; 260 such errors -> err_count_o=255.
REQ-026 Hold resp_yumi_i low 5 cycles with cmd_v_i high -> cmd_ready_o=0 and resp_* stable throughout; yumi on cycle 5 -> next command accepted on cycle 6.
REQ-027 Back-to-back commands with resp_yumi_i tied high -> one response every 2 cycles; payloads echoed in order.
REQ-028 Assert reset_n_i low mid-RESP, asynchronously between clock edges -> resp_v_o falls immediately; registers read 0 after release.
